fp32_sum_capture: RTL and testbench

- Downstream stage of the combinational float32 adder (testAddRecFN). Takes each outputSum word with a valid/ready handshake and buffers it in a 2-entry FIFO.
- Classifies each word as zero, subnormal, normal, inf, qNaN or sNaN, and keeps saturating event counters.
- Presents registered results and class codes to the consumer (result bus or checker).

---
 rtl/fp32_sum_capture.sv | 148 ++++++++++++++
 tb/tb_fp32_sum_capture.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_sum_capture.sv
// Capture stage for float32 adder sums: 2-entry FIFO, IEEE class tagging, event counters.
// Optional FP32_CANON_NAN_EN replaces every NaN with the canonical quiet NaN 0x7FC00000.
module fp32_sum_capture #(
   parameter int CNT_W = 16,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_sum,
   output logic             out_sign,
   output logic [2:0]       out_class,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] zero_cnt,
   output logic [CNT_W-1:0] inf_cnt,
   output logic [CNT_W-1:0] nan_cnt
);

   generate
      if (DEPTH != 2) begin : g_depth_chk
         $error("fp32_sum_capture: DEPTH must be 2");
      end
   endgenerate

   localparam logic [2:0] C_ZERO = 3'd0;
   localparam logic [2:0] C_SUB  = 3'd1;
   localparam logic [2:0] C_NORM = 3'd2;
   localparam logic [2:0] C_INF  = 3'd3;
   localparam logic [2:0] C_QNAN = 3'd4;
   localparam logic [2:0] C_SNAN = 3'd5;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } occ_t;

   occ_t        state;
   occ_t        state_nxt;
   logic        push;
   logic        pop;
   logic        wr_ptr;
   logic        rd_ptr;
   logic [31:0] mem_sum [2];
   logic [2:0]  mem_cls [2];

   logic [7:0]  exp_f;
   logic [22:0] frac_f;
   logic [2:0]  cls_in;
   logic        is_nan;
   logic [31:0] word_in;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_comb begin
      exp_f  = in_sum[30:23];
      frac_f = in_sum[22:0];
      cls_in = C_NORM;
      unique case (1'b1)
         (exp_f == 8'h00) && (frac_f == 23'd0): cls_in = C_ZERO;
         (exp_f == 8'h00) && (frac_f != 23'd0): cls_in = C_SUB;
         (exp_f == 8'hFF) && (frac_f == 23'd0): cls_in = C_INF;
         (exp_f == 8'hFF) && frac_f[22]:        cls_in = C_QNAN;
         (exp_f == 8'hFF) && (frac_f != 23'd0)
            && !frac_f[22]:                     cls_in = C_SNAN;
         default:                               cls_in = C_NORM;
      endcase
   end

   assign is_nan = (cls_in == C_QNAN) || (cls_in == C_SNAN);

`ifdef FP32_CANON_NAN_EN
   assign word_in = is_nan ? 32'h7FC0_0000 : in_sum;
`else
   assign word_in = in_sum;
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_EMPTY: if (push) state_nxt = S_ONE;
         S_ONE: begin
            if (push && !pop)      state_nxt = S_FULL;
            else if (pop && !push) state_nxt = S_EMPTY;
         end
         S_FULL:  if (pop) state_nxt = S_ONE;
         default: state_nxt = S_EMPTY;
      endcase
   end

   // Handshake flags come only from the occupancy register.
   assign in_ready  = (state != S_FULL);
   assign out_valid = (state != S_EMPTY);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         mem_sum[0] <= 32'd0;
         mem_sum[1] <= 32'd0;
         mem_cls[0] <= 3'd0;
         mem_cls[1] <= 3'd0;
      end else begin
         if (push) begin
            mem_sum[wr_ptr] <= word_in;
            mem_cls[wr_ptr] <= cls_in;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
      end
   end

   assign out_sum   = mem_sum[rd_ptr];
   assign out_sign  = out_sum[31];
   assign out_class = mem_cls[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_cnt <= '0;
         inf_cnt  <= '0;
         nan_cnt  <= '0;
      end else if (clr_cnt) begin
         zero_cnt <= '0;
         inf_cnt  <= '0;
         nan_cnt  <= '0;
      end else if (push) begin
         if ((cls_in == C_ZERO) && !(&zero_cnt)) zero_cnt <= zero_cnt + 1'b1;
         if ((cls_in == C_INF) && !(&inf_cnt))   inf_cnt  <= inf_cnt + 1'b1;
         if (is_nan && !(&nan_cnt))              nan_cnt  <= nan_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_fp32_sum_capture.sv
// Scoreboard bench for fp32_sum_capture: directed scenarios plus randomized traffic.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_fp32_sum_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_sum;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic        out_sign;
   logic [2:0]  out_class;
   logic        clr_cnt;
   logic [15:0] zero_cnt;
   logic [15:0] inf_cnt;
   logic [15:0] nan_cnt;

   logic        v2;
   logic        rdy2;
   logic [31:0] s2;
   logic        ov2;
   logic [31:0] os2;
   logic        osg2;
   logic [2:0]  oc2;
   logic [1:0]  z2;
   logic [1:0]  i2;
   logic [1:0]  n2;

   int passes = 0;
   int total  = 0;
   int m_zero = 0;
   int m_inf  = 0;
   int m_nan  = 0;
   bit rnd    = 0;

   typedef struct {
      logic [31:0] sum;
      logic        sign;
      logic [2:0]  cls;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   fp32_sum_capture #(.CNT_W(16), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_sign(out_sign), .out_class(out_class),
      .clr_cnt(clr_cnt),
      .zero_cnt(zero_cnt), .inf_cnt(inf_cnt), .nan_cnt(nan_cnt)
   );

   fp32_sum_capture #(.CNT_W(2), .DEPTH(2)) dut2 (
      .clk(clk), .rst(rst),
      .in_valid(v2), .in_ready(), .in_sum(s2),
      .out_valid(ov2), .out_ready(rdy2),
      .out_sum(os2), .out_sign(osg2), .out_class(oc2),
      .clr_cnt(1'b0),
      .zero_cnt(z2), .inf_cnt(i2), .nan_cnt(n2)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t",
                    name, act, exp, $time);
   endtask

   function automatic exp_t model(input logic [31:0] w);
      exp_t e;
      int unsigned ex;
      int unsigned fr;
      ex = w[30:23];
      fr = w[22:0];
      if (ex == 0)        e.cls = (fr == 0) ? 3'd0 : 3'd1;
      else if (ex != 255) e.cls = 3'd2;
      else if (fr == 0)   e.cls = 3'd3;
      else if (fr >= 32'h40_0000) e.cls = 3'd4;
      else                e.cls = 3'd5;
      e.sum = w;
`ifdef FP32_CANON_NAN_EN
      if (e.cls >= 3'd4) e.sum = 32'h7FC0_0000;
`endif
      e.sign = e.sum[31];
      return e;
   endfunction

   function automatic int sat(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   // Records accepted words and the counter model just before each edge.
   always @(negedge clk) begin
      #1;
      if (!rst) begin
         if (in_valid && in_ready) q.push_back(model(in_sum));
         if (clr_cnt) begin
            m_zero = 0; m_inf = 0; m_nan = 0;
         end else if (in_valid && in_ready) begin
            exp_t e;
            e = model(in_sum);
            if (e.cls == 3'd0) m_zero = sat(m_zero);
            if (e.cls == 3'd3) m_inf  = sat(m_inf);
            if (e.cls >= 3'd4) m_nan  = sat(m_nan);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
         chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
         chk("zero_cnt", 32'(zero_cnt), 32'(m_zero));
         chk("inf_cnt", 32'(inf_cnt), 32'(m_inf));
         chk("nan_cnt", 32'(nan_cnt), 32'(m_nan));
         if (out_valid && out_ready && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("out_sum", out_sum, e.sum);
            chk("out_sign", 32'(out_sign), 32'(e.sign));
            chk("out_class", 32'(out_class), 32'(e.cls));
         end
      end
   end

   task automatic send(input logic [31:0] w);
      bit acc;
      int n;
      in_valid = 1'b1;
      in_sum   = w;
      acc      = 0;
      n        = 0;
      while (!acc && n < 500) begin
         @(negedge clk);
         #1;
         acc = in_ready;
         @(posedge clk);
         #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         n++;
      end
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      logic [22:0] f;
      w = $urandom;
      f = w[22:0];
      case ($urandom_range(0, 5))
         0: w = {w[31], 31'd0};
         1: w = {w[31], 8'h00, (f == 0) ? 23'd1 : f};
         2: w = {w[31], 8'($urandom_range(1, 254)), f};
         3: w = {w[31], 8'hFF, 23'd0};
         4: w = {w[31], 8'hFF, 1'b1, f[21:0]};
         default: w = {w[31], 8'hFF, 1'b0,
                       (f[21:0] == 0) ? 22'd1 : f[21:0]};
      endcase
      return w;
   endfunction

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_sum    = 32'd0;
      out_ready = 1'b0;
      clr_cnt   = 1'b0;
      v2        = 1'b0;
      s2        = 32'd0;
      rdy2      = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_sum", out_sum, 32'd0);
      chk("rst_out_class", 32'(out_class), 32'd0);
      chk("rst_zero_cnt", 32'(zero_cnt), 32'd0);
      cycles(2);
      rst = 1'b0;
      cycles(1);

      out_ready = 1'b1;
      send(32'h40C0_0000);
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_sum", out_sum, 32'h40C0_0000);
      chk("lat_class", 32'(out_class), 32'd2);
      chk("lat_sign", 32'(out_sign), 32'd0);
      cycles(1);
      chk("lat_drop", 32'(out_valid), 32'd0);
      send(32'h0000_0000);
      chk("zero_one", 32'(zero_cnt), 32'd1);
      cycles(2);

      out_ready = 1'b0;
      send(32'h3F80_0000);
      send(32'hBF80_0000);
      chk("bp_full", 32'(in_ready), 32'd0);
      fork
         send(32'h4000_0000);
         begin
            cycles(3);
            out_ready = 1'b1;
         end
      join
      cycles(4);

      send(32'h3F80_0000);
      send(32'h4000_0000);
      send(32'h4040_0000);
      cycles(3);

      clr_cnt = 1'b1;
      cycles(1);
      clr_cnt = 1'b0;
      send(32'h7F80_0000);
      send(32'hFF80_0000);
      send(32'h7FC0_0001);
      send(32'h7F80_0001);
      send(32'h0000_0001);
      send(32'h8000_0000);
      cycles(3);
      chk("cls_inf", 32'(inf_cnt), 32'd2);
      chk("cls_nan", 32'(nan_cnt), 32'd2);
      chk("cls_zero", 32'(zero_cnt), 32'd1);

      clr_cnt = 1'b1;
      send(32'h0000_0000);
      clr_cnt = 1'b0;
      chk("clr_push", 32'(zero_cnt), 32'd0);
      cycles(2);

      for (int i = 0; i < 5; i++) begin
         v2 = 1'b1;
         s2 = 32'd0;
         cycles(1);
         v2 = 1'b0;
         cycles(1);
         chk("sat_cnt", 32'(z2), (i >= 2) ? 32'd3 : 32'(i + 1));
      end

      rnd = 1;
      for (int i = 0; i < 300; i++) begin
         clr_cnt = ($urandom_range(0, 15) == 0);
         send(rand_word());
         clr_cnt = 1'b0;
         if ($urandom_range(0, 3) == 0) cycles(1);
      end
      rnd = 0;
      out_ready = 1'b1;
      cycles(4);

      out_ready = 1'b0;
      send(32'h0000_0000);
      send(32'h8000_0000);
      chk("pre_rst_full", 32'(in_ready), 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_zero", 32'(zero_cnt), 32'd0);
      chk("mid_rst_inf", 32'(inf_cnt), 32'd0);
      chk("mid_rst_nan", 32'(nan_cnt), 32'd0);
      chk("mid_rst_sum", out_sum, 32'd0);
      q.delete();
      m_zero = 0;
      m_inf  = 0;
      m_nan  = 0;
      cycles(1);
      rst = 1'b0;
      out_ready = 1'b1;
      send(32'h4040_0000);
      cycles(3);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
